line_buffer_bank_ctrl: RTL and testbench

//  Generalised successor of the two-bank ping/pong control. Rotates NUM_BANKS single-row line-buffer banks.

---
 rtl/line_buffer_bank_ctrl_if.sv | 50 +++++
 rtl/line_buffer_bank_ctrl.sv | 162 ++++++++++++++++
 tb/tb_line_buffer_bank_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_buffer_bank_ctrl_if
// Purpose : groups the pixel-in handshake, bank write strobes, the read
//           command handshake and the status flags of the line-buffer bank
//           controller into one bundle.
// Signals :
//   start         frame start request (sampled by the controller in IDLE)
//   in_valid      source has a pixel
//   in_ready      controller accepts a pixel
//   wr_en         one-hot bank write strobe
//   wr_addr       write column
//   rd_cmd_valid  read command available
//   rd_cmd_ready  downstream accepts the read command
//   rd_en         window bank mask, qualified by read fire
//   rd_addr       read column
//   rd_base_bank  bank holding the oldest (top) window row
//   busy          controller is inside a frame
//   frame_done    one-cycle end-of-frame pulse
// Modports: master = controller side, slave = source / window-stage side.
// ---------------------------------------------------------------------------
interface line_buffer_bank_ctrl_if #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_SIZE = 4,
    parameter int BANK_W    = 2
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_BANKS-1:0] wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic                 rd_cmd_valid;
    logic                 rd_cmd_ready;
    logic [NUM_BANKS-1:0] rd_en;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [BANK_W-1:0]    rd_base_bank;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  start, in_valid, rd_cmd_ready,
        output in_ready, wr_en, wr_addr, rd_cmd_valid, rd_en, rd_addr,
               rd_base_bank, busy, frame_done
    );

    modport slave (
        output start, in_valid, rd_cmd_ready,
        input  in_ready, wr_en, wr_addr, rd_cmd_valid, rd_en, rd_addr,
               rd_base_bank, busy, frame_done
    );
endinterface

// File: rtl/line_buffer_bank_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_bank_ctrl
// Purpose : rotates NUM_BANKS single-row line-buffer banks. Incoming pixels
//           are written row by row (row r -> bank r mod NUM_BANKS) while
//           KERNEL_SIZE-row read commands are issued to the window/MAC stage
//           for rows that are already complete. Writes never overtake the
//           oldest bank still inside the read window.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   line_buffer_bank_ctrl_if.master (handshakes, strobes, status)
// Parameter constraints: 2 <= KERNEL_SIZE <= IMAGE_H,
//   NUM_BANKS >= KERNEL_SIZE+1, widths as $clog2 of their ranges.
// ---------------------------------------------------------------------------
module line_buffer_bank_ctrl #(
    parameter int IMAGE_W     = 16,
    parameter int IMAGE_H     = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_SIZE   = 4,
    parameter int ROW_W       = 5,
    parameter int BANK_W      = 2
) (
    input  logic clk,
    input  logic rst,
    line_buffer_bank_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Row comparisons are done in a widened domain so rd_row+NUM_BANKS and
    // rd_row+KERNEL_SIZE cannot overflow.
    localparam int CMP_W = ROW_W + BANK_W + 2;
    localparam logic [CMP_W-1:0]     IMG_H_C    = CMP_W'(IMAGE_H);
    localparam logic [CMP_W-1:0]     KSZ_C      = CMP_W'(KERNEL_SIZE);
    localparam logic [CMP_W-1:0]     NB_C       = CMP_W'(NUM_BANKS);
    localparam logic [CMP_W-1:0]     LAST_RD_C  = CMP_W'(IMAGE_H - KERNEL_SIZE);
    localparam logic [CMP_W-1:0]     RD_END_C   = CMP_W'(IMAGE_H - KERNEL_SIZE + 1);
    localparam logic [ADDR_SIZE-1:0] COL_LAST   = ADDR_SIZE'(IMAGE_W - 1);
    localparam logic [BANK_W-1:0]    BANK_LAST  = BANK_W'(NUM_BANKS - 1);
    localparam logic [BANK_W:0]      NB_B       = (BANK_W+1)'(NUM_BANKS);
    localparam logic [BANK_W:0]      KSZ_B      = (BANK_W+1)'(KERNEL_SIZE);

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_SIZE-1:0] wr_col;
    logic [ADDR_SIZE-1:0] rd_col;
    logic [ROW_W-1:0]     wr_row;
    logic [ROW_W-1:0]     rd_row;
    // Bank indices track row mod NUM_BANKS incrementally instead of dividing.
    logic [BANK_W-1:0]    wr_bank;
    logic [BANK_W-1:0]    rd_bank;

    logic [CMP_W-1:0]     wr_row_x;
    logic [CMP_W-1:0]     rd_row_x;
    logic                 in_ready;
    logic                 rd_cmd_valid;
    logic                 wfire;
    logic                 rfire;

    assign wr_row_x = CMP_W'(wr_row);
    assign rd_row_x = CMP_W'(rd_row);

    // Write side stalls once it would reach the bank holding the top window row.
    assign in_ready = ((state == FILL) || (state == STREAM)) &&
                      (wr_row_x < IMG_H_C) &&
                      (wr_row_x < rd_row_x + NB_C);

    // A window may be read only when all KERNEL_SIZE of its rows are written.
    assign rd_cmd_valid = ((state == STREAM) || (state == DRAIN)) &&
                          (rd_row_x + KSZ_C <= wr_row_x) &&
                          (rd_row_x <= LAST_RD_C);

    assign wfire = in_ready && bus.in_valid;
    assign rfire = rd_cmd_valid && bus.rd_cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)               state_nxt = FILL;
            FILL:    if (wr_row_x >= KSZ_C)       state_nxt = STREAM;
            STREAM:  if (wr_row_x >= IMG_H_C)     state_nxt = DRAIN;
            DRAIN:   if (rd_row_x >= RD_END_C)    state_nxt = DONE;
            DONE:                                 state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Counters: column wraps advance the row and its bank; DONE clears
    // everything so IDLE always starts from row 0 / bank 0 / column 0.
    always_ff @(posedge clk) begin
        if (!rst || (state == DONE)) begin
            wr_col  <= '0;
            wr_row  <= '0;
            wr_bank <= '0;
            rd_col  <= '0;
            rd_row  <= '0;
            rd_bank <= '0;
        end else begin
            if (wfire) begin
                if (wr_col == COL_LAST) begin
                    wr_col  <= '0;
                    wr_row  <= wr_row + ROW_W'(1);
                    wr_bank <= (wr_bank == BANK_LAST) ? '0 : wr_bank + BANK_W'(1);
                end else begin
                    wr_col <= wr_col + ADDR_SIZE'(1);
                end
            end
            if (rfire) begin
                if (rd_col == COL_LAST) begin
                    rd_col  <= '0;
                    rd_row  <= rd_row + ROW_W'(1);
                    rd_bank <= (rd_bank == BANK_LAST) ? '0 : rd_bank + BANK_W'(1);
                end else begin
                    rd_col <= rd_col + ADDR_SIZE'(1);
                end
            end
        end
    end

    // Strobes: wr_en is one-hot on the write bank; rd_en selects the
    // KERNEL_SIZE banks starting at rd_bank, wrapping past the last bank.
    always_comb begin
        logic [BANK_W:0] bx;
        logic [BANK_W:0] base;
        logic [BANK_W:0] off;
        bus.wr_en = '0;
        bus.rd_en = '0;
        bx   = '0;
        off  = '0;
        base = (BANK_W+1)'(rd_bank);
        for (int b = 0; b < NUM_BANKS; b++) begin
            bx            = (BANK_W+1)'(b);
            off           = (bx >= base) ? (bx - base) : (bx + NB_B - base);
            bus.wr_en[b]  = wfire && (wr_bank == BANK_W'(b));
            bus.rd_en[b]  = rfire && (off < KSZ_B);
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wr_addr      = wr_col;
    assign bus.rd_cmd_valid = rd_cmd_valid;
    assign bus.rd_addr      = rd_col;
    assign bus.rd_base_bank = rd_bank;
    assign bus.busy         = (state != IDLE);
    assign bus.frame_done   = (state == DONE);

endmodule

// File: tb/tb_line_buffer_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_bank_ctrl
// Purpose : directed bench for line_buffer_bank_ctrl at default parameters
//           (16x16 image, 3-row kernel, 4 banks). A negedge monitor logs
//           every write/read fire; the main sequence compares the logs and
//           live outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_line_buffer_bank_ctrl;

    localparam int LOG_N = 2048;

    logic clk;
    logic rst;

    line_buffer_bank_ctrl_if #(.NUM_BANKS(4), .ADDR_SIZE(4), .BANK_W(2)) bus ();

    line_buffer_bank_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fire logs, filled on the falling edge with the values the next rising
    // edge will sample.
    int       wcnt = 0;
    int       rcnt = 0;
    int       fd_cnt = 0;
    logic [3:0] w_en_log   [0:LOG_N-1];
    logic [3:0] w_addr_log [0:LOG_N-1];
    int         w_cyc      [0:LOG_N-1];
    int         w_rc       [0:LOG_N-1];
    logic [3:0] r_en_log   [0:LOG_N-1];
    int         r_cyc      [0:LOG_N-1];

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            if (wcnt < LOG_N) begin
                w_en_log[wcnt]   = bus.wr_en;
                w_addr_log[wcnt] = bus.wr_addr;
                w_cyc[wcnt]      = cyc;
                w_rc[wcnt]       = rcnt;
            end
            wcnt = wcnt + 1;
        end
        if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
            if (rcnt < LOG_N) begin
                r_en_log[rcnt] = bus.rd_en;
                r_cyc[rcnt]    = cyc;
            end
            rcnt = rcnt + 1;
        end
        if (bus.frame_done) fd_cnt = fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int fd_base, input string tag);
        int n;
        n = 0;
        while ((fd_cnt == fd_base) && (n < 2000)) begin
            tick();
            n++;
        end
        if (fd_cnt == fd_base) chk({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_wcnt(input int target, input string tag);
        int n;
        n = 0;
        while ((wcnt < target) && (n < 2000)) begin
            tick();
            n++;
        end
        if (wcnt < target) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(bus.wr_en), 32'd0);
        chk({tag, "_wr_addr"},  32'(bus.wr_addr), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_cmd_valid), 32'd0);
        chk({tag, "_rd_en"},    32'(bus.rd_en), 32'd0);
        chk({tag, "_rd_addr"},  32'(bus.rd_addr), 32'd0);
        chk({tag, "_rd_base"},  32'(bus.rd_base_bank), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy), 32'd0);
        chk({tag, "_fdone"},    32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp_masks [0:4];

    initial begin
        int w0, r0, f0;
        exp_masks[0] = 4'b0111;
        exp_masks[1] = 4'b1110;
        exp_masks[2] = 4'b1101;
        exp_masks[3] = 4'b1011;
        exp_masks[4] = 4'b0111;

        // Reset with both handshakes asserted.
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.in_valid     = 1'b1;
        bus.rd_cmd_ready = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        rst = 1'b1;
        tick();
        chk_idle("idle");

        // Full frame, both sides always willing; a stray start mid-frame.
        w0 = wcnt; r0 = rcnt; f0 = fd_cnt;
        pulse_start();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        wait_wcnt(w0 + 100, "mid");
        pulse_start();
        wait_done(f0, "frame1");
        chk("f1_wfires", 32'(wcnt - w0), 32'd256);
        chk("f1_rfires", 32'(rcnt - r0), 32'd224);
        chk("f1_fdone",  32'(fd_cnt - f0), 32'd1);
        chk("f1_busy",   32'(bus.busy), 32'd0);
        chk("f1_first_rd_gap", 32'(r_cyc[r0] - w_cyc[w0 + 47]), 32'd2);
        for (int i = 0; i < 5; i++)
            chk($sformatf("f1_mask_row%0d", i), 32'(r_en_log[r0 + 16*i]), 32'(exp_masks[i]));
        chk("f1_wr_en_row1", 32'(w_en_log[w0 + 16]), 32'h2);
        chk("f1_wr_en_row3", 32'(w_en_log[w0 + 63]), 32'h8);
        chk("f1_wr_en_row4", 32'(w_en_log[w0 + 64]), 32'h1);
        chk("f1_wr_addr_c5", 32'(w_addr_log[w0 + 21]), 32'd5);

        // Downstream never ready: writer fills all four banks and stalls.
        w0 = wcnt; r0 = rcnt; f0 = fd_cnt;
        bus.rd_cmd_ready = 1'b0;
        pulse_start();
        repeat (200) tick();
        chk("bp_wfires",   32'(wcnt - w0), 32'd64);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_rd_valid", 32'(bus.rd_cmd_valid), 32'd1);
        chk("bp_rd_base",  32'(bus.rd_base_bank), 32'd0);
        bus.rd_cmd_ready = 1'b1;
        wait_wcnt(w0 + 65, "bp_resume");
        chk("bp_resume_after_rows", 32'(w_rc[w0 + 64] - r0), 32'd16);
        wait_done(f0, "frame2");
        chk("f2_wfires", 32'(wcnt - w0), 32'd256);
        chk("f2_rfires", 32'(rcnt - r0), 32'd224);
        chk("f2_fdone",  32'(fd_cnt - f0), 32'd1);

        // Source pauses at row 3 column 5: reads stop after row 0.
        w0 = wcnt; r0 = rcnt; f0 = fd_cnt;
        pulse_start();
        wait_wcnt(w0 + 53, "pause");
        bus.in_valid = 1'b0;
        repeat (100) tick();
        chk("pause_wfires",   32'(wcnt - w0), 32'd53);
        chk("pause_rfires",   32'(rcnt - r0), 32'd16);
        chk("pause_rd_valid", 32'(bus.rd_cmd_valid), 32'd0);
        chk("pause_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        wait_done(f0, "frame3");
        chk("pause_rd_resume_gap", 32'(r_cyc[r0 + 16] - w_cyc[w0 + 63]), 32'd1);
        chk("f3_wfires", 32'(wcnt - w0), 32'd256);
        chk("f3_rfires", 32'(rcnt - r0), 32'd224);

        // Reset in the middle of row 7, then a clean restart.
        w0 = wcnt; f0 = fd_cnt;
        pulse_start();
        wait_wcnt(w0 + 112, "mid_rst");
        rst = 1'b0;
        tick();
        chk_idle("mid_rst");
        rst = 1'b1;
        repeat (4) tick();
        chk("mid_rst_no_fdone", 32'(fd_cnt - f0), 32'd0);
        chk("mid_rst_busy",     32'(bus.busy), 32'd0);
        w0 = wcnt; r0 = rcnt; f0 = fd_cnt;
        pulse_start();
        repeat (3) tick();
        chk("restart_wr_en",   32'(w_en_log[w0]), 32'h1);
        chk("restart_wr_addr", 32'(w_addr_log[w0]), 32'd0);
        wait_done(f0, "frame4");
        chk("f4_wfires", 32'(wcnt - w0), 32'd256);
        chk("f4_rfires", 32'(rcnt - r0), 32'd224);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
